// File: rtl/sprite_table_loader.sv
// Streams one cluster's sprite attribute table from the sprite RAM into the position
// register file: one RAM read per cycle, and each word is written two cycles after its read.
module sprite_table_loader #(
  parameter int ADDR_WIDTH     = 16,
  parameter int INT_WIDTH      = 16,
  parameter int CLUSTER_SIZE   = 20,
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_ren,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [INT_WIDTH-1:0]      mem_rdata,
  output logic [ADDR_WIDTH-1:0]     waddr,
  output logic [INT_WIDTH-1:0]      wdata,
  output logic                      wen
);

  localparam int TOTAL = CLUSTER_SIZE * 6;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(TOTAL - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t                    r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]     r_rd_idx, w_rd_idx_nxt;
  logic [MEM_ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic                      r_mem_ren, r_busy, r_done;
  logic                      r_p1_vld;
  logic [ADDR_WIDTH-1:0]     r_p1_idx;
  logic                      r_wen;
  logic [ADDR_WIDTH-1:0]     r_waddr;
  logic [INT_WIDTH-1:0]      r_wdata;
  logic                      w_kill;

  // abort only matters once a load is under way; in IDLE it merely vetoes start
  assign w_kill = abort && (r_state != S_IDLE);

  always_comb begin
    w_state_nxt    = r_state;
    w_rd_idx_nxt   = r_rd_idx;
    w_mem_addr_nxt = r_mem_addr;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt    = S_FETCH;
          w_rd_idx_nxt   = '0;
          w_mem_addr_nxt = base_addr;
        end
      end
      S_FETCH: begin
        if (r_rd_idx == LAST_IDX) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_rd_idx_nxt   = r_rd_idx + 1'b1;
          w_mem_addr_nxt = r_mem_addr + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_wen && (r_waddr == LAST_IDX)) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_kill) w_state_nxt = S_IDLE;
    if (w_state_nxt != S_FETCH) begin
      w_rd_idx_nxt   = '0;
      w_mem_addr_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_rd_idx   <= '0;
      r_mem_addr <= '0;
      r_mem_ren  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_p1_vld   <= 1'b0;
      r_p1_idx   <= '0;
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_idx   <= w_rd_idx_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_mem_ren  <= (w_state_nxt == S_FETCH);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_DONE);
      // stage 1 tracks the read the RAM is answering; stage 2 presents the write
      r_p1_vld   <= r_mem_ren && !w_kill;
      r_p1_idx   <= r_rd_idx;
      r_wen      <= r_p1_vld && !w_kill;
      r_waddr    <= (r_p1_vld && !w_kill) ? r_p1_idx : '0;
      r_wdata    <= (r_p1_vld && !w_kill) ? mem_rdata : '0;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign mem_ren  = r_mem_ren;
  assign mem_addr = r_mem_addr;
  assign wen      = r_wen;
  assign waddr    = r_waddr;
  assign wdata    = r_wdata;

endmodule

// File: tb/tb_sprite_table_loader.sv
// Bench for sprite_table_loader: table-driven and random loads checked cycle by cycle
// against an arithmetic model of when each output should be active.
module tb_sprite_table_loader;

  localparam int TOTAL = 120;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] base_addr = '0;
  logic        busy, done, mem_ren, wen;
  logic [15:0] mem_addr, mem_rdata, waddr, wdata;
  logic [15:0] mem_key = 16'hA5A5;

  int checks = 0;
  int errors = 0;

  sprite_table_loader #(
    .ADDR_WIDTH(16), .INT_WIDTH(16), .CLUSTER_SIZE(20), .MEM_ADDR_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
    .busy(busy), .done(done), .mem_ren(mem_ren), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .waddr(waddr), .wdata(wdata), .wen(wen)
  );

  always #5 clk = ~clk;

  // synchronous sprite RAM: word content is address xor a per-load key
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem_addr ^ mem_key;
  end

  typedef struct {
    logic [15:0] base;
    int          s2;      // cycle of a second start pulse, 0 = none
    int          a_edge;  // edge at which abort is sampled, 0 = none
    int          exp_wen;
    int          exp_done;
  } vec_t;

  vec_t vecs[8];

  task automatic check_all_zero(input string name);
    checks++;
    if ({busy, done, mem_ren, mem_addr, wen, waddr, wdata} != '0) begin
      errors++;
      $display("FAIL %s got busy=%b done=%b ren=%b addr=%h wen=%b waddr=%0d wdata=%h required all 0",
               name, busy, done, mem_ren, mem_addr, wen, waddr, wdata);
    end
  endtask

  // Starts a load at edge 0 and checks cycles 1..TOTAL+6 against the model.
  task automatic run_load(input logic [15:0] base, input logic [15:0] key, input int s2,
                          input int a_edge, input string name,
                          output int nwen, output int ndone);
    logic        act, e_busy, e_done, e_ren, e_wen;
    logic [15:0] e_addr, e_waddr, e_wdata;
    logic [51:0] got, exp;
    nwen = 0;
    ndone = 0;
    @(negedge clk);
    mem_key   = key;
    base_addr = base;
    start     = 1'b1;
    abort     = (a_edge == 1);
    for (int c = 1; c <= TOTAL + 6; c++) begin
      @(negedge clk);
      act     = (a_edge == 0) || (c < a_edge);
      e_busy  = act && (c >= 1) && (c <= TOTAL + 3);
      e_done  = act && (c == TOTAL + 3);
      e_ren   = act && (c <= TOTAL);
      e_wen   = act && (c >= 3) && (c <= TOTAL + 2);
      e_addr  = base + 16'(c - 1);
      e_waddr = 16'(c - 3);
      e_wdata = (base + 16'(c - 3)) ^ key;
      got = {busy, done, mem_ren, (mem_ren ? mem_addr : 16'h0), wen,
             (wen ? waddr : 16'h0), (wen ? wdata : 16'h0)};
      exp = {e_busy, e_done, e_ren, (e_ren ? e_addr : 16'h0), e_wen,
             (e_wen ? e_waddr : 16'h0), (e_wen ? e_wdata : 16'h0)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s cyc%0d got busy=%b done=%b ren=%b addr=%h wen=%b waddr=%0d wdata=%h required busy=%b done=%b ren=%b addr=%h wen=%b waddr=%0d wdata=%h",
                 name, c, busy, done, mem_ren, mem_addr, wen, waddr, wdata,
                 e_busy, e_done, e_ren, e_addr, e_wen, e_waddr, e_wdata);
      end
      if (wen) nwen++;
      if (done) ndone++;
      start     = (s2 == c);
      abort     = (a_edge == c + 1);
      base_addr = 16'($urandom);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic check_counts(input string name, input int nwen, input int ndone,
                              input int exp_wen, input int exp_done);
    checks++;
    if (nwen != exp_wen || ndone != exp_done) begin
      errors++;
      $display("FAIL %s counts got wen=%0d done=%0d required wen=%0d done=%0d",
               name, nwen, ndone, exp_wen, exp_done);
    end
  endtask

  initial begin
    int nw, nd, a, s;
    logic [15:0] b, k;

    vecs[0] = '{16'h0100,   0,   0, 120, 1};  // plain load
    vecs[1] = '{16'h0100,  50,   0, 120, 1};  // restart attempt mid-load
    vecs[2] = '{16'h0100,   0,  40,  37, 0};  // abort at edge 40
    vecs[3] = '{16'hFFF8,   0,   0, 120, 1};  // RAM address wrap
    vecs[4] = '{16'h2000, 123,   0, 120, 1};  // start during DONE cycle
    vecs[5] = '{16'h0300,   0,   1,   0, 0};  // abort together with start
    vecs[6] = '{16'h0400,   0, 122, 119, 0};  // abort while draining
    vecs[7] = '{16'h0500,   0, 124, 120, 1};  // abort in DONE cycle

    // reset held with random inputs
    for (int i = 0; i < 8; i++) begin
      start     = 1'($urandom);
      abort     = 1'($urandom);
      base_addr = 16'($urandom);
      @(negedge clk);
      check_all_zero("reset_hold");
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_all_zero("after_reset");
    end

    for (int i = 0; i < 8; i++) begin
      run_load(vecs[i].base, 16'hA5A5, vecs[i].s2, vecs[i].a_edge, $sformatf("vec%0d", i), nw, nd);
      check_counts($sformatf("vec%0d", i), nw, nd, vecs[i].exp_wen, vecs[i].exp_done);
    end

    // complete load after an aborted one
    run_load(16'h0100, 16'hA5A5, 0, 0, "post_abort", nw, nd);
    check_counts("post_abort", nw, nd, 120, 1);

    // asynchronous reset in the middle of cycle 60
    @(negedge clk);
    base_addr = 16'h0100;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (60) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    check_all_zero("async_reset_hold");
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({wen, done, busy, mem_ren} != 4'b0) begin
        errors++;
        $display("FAIL post_reset_idle got wen=%b done=%b busy=%b ren=%b required 0",
                 wen, done, busy, mem_ren);
      end
    end
    run_load(16'h0000, 16'hA5A5, 0, 0, "after_async_reset", nw, nd);
    check_counts("after_async_reset", nw, nd, 120, 1);

    // random loads
    for (int i = 0; i < 15; i++) begin
      b = 16'($urandom);
      k = 16'($urandom);
      a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 126)) : 0;
      if (a == 1) s = 0;
      else if ($urandom_range(0, 1) == 0) s = 0;
      else s = int'($urandom_range(1, (a == 0) ? 123 : ((a - 1 < 123) ? a - 1 : 123)));
      run_load(b, k, s, a, $sformatf("rand%0d", i), nw, nd);
      check_counts($sformatf("rand%0d", i), nw, nd,
                   (a == 0) ? 120 : ((a - 1 < 122 ? a - 1 : 122) - 2 > 0 ? (a - 1 < 122 ? a - 1 : 122) - 2 : 0),
                   (a == 0 || a > 123) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
